// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign fix-up in a final cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [5:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   divisor;

    logic               a_neg, b_neg, div_zero;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   diff;
    logic               no_borrow;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    always_comb begin
        a_neg     = ~Op[0] & A[WIDTH-1];
        b_neg     = ~Op[0] & B[WIDTH-1];
        a_mag     = a_neg ? (~A + 1'b1) : A;
        b_mag     = b_neg ? (~B + 1'b1) : B;
        div_zero  = (B == '0);
        rem_sh    = {rem, quo[WIDTH-1]};
        diff      = {1'b0, rem_sh} - {2'b00, divisor};
        no_borrow = ~diff[WIDTH+1];
        prod_fix  = neg_q ? (~prod + 1'b1) : prod;
        q_fix     = neg_q ? (~quo + 1'b1) : quo;
        r_fix     = neg_r ? (~rem + 1'b1) : rem;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            prod    <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        case (Op)
                            OP_MTHI: HI <= A;
                            OP_MTLO: LO <= A;
                            OP_MULT, OP_MULTU: begin
                                mcand  <= {{WIDTH{1'b0}}, a_mag};
                                mplier <= b_mag;
                                prod   <= '0;
                                neg_q  <= a_neg ^ b_neg;
                                neg_r  <= 1'b0;
                                is_div <= 1'b0;
                                count  <= '0;
                                Busy   <= 1'b1;
                                state  <= MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                // Divide by zero keeps the raw dividend so the remainder comes out as A.
                                quo     <= div_zero ? A : a_mag;
                                rem     <= '0;
                                divisor <= b_mag;
                                neg_q   <= ~div_zero & (a_neg ^ b_neg);
                                neg_r   <= ~div_zero & a_neg;
                                is_div  <= 1'b1;
                                count   <= '0;
                                Busy    <= 1'b1;
                                state   <= DIV;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) state <= FIX;
                end
                DIV: begin
                    rem   <= no_borrow ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    quo   <= {quo[WIDTH-2:0], no_borrow};
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        HI <= r_fix;
                        LO <= q_fix;
                    end else begin
                        HI <= prod_fix[2*WIDTH-1:WIDTH];
                        LO <= prod_fix[WIDTH-1:0];
                    end
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit: each task drives a scenario and checks inline.
module tb_mul_div_unit;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    logic        clk, reset, Start, Busy, Done;
    logic [5:0]  Op;
    logic [31:0] A, B, HI, LO;

    int checks = 0;
    int fails  = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge: presents a request for one rising edge, returns at the next negedge.
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; Op = op; A = a; B = b;
        @(negedge clk);
        Start = 1'b0; Op = 6'b0; A = '0; B = '0;
    endtask

    // Counts negedges with Busy high (bounded); returns at the first negedge with Busy low.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (Busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            fails++;
            $display("FAIL reset_state: Busy=%b Done=%b HI=%h LO=%h, want 0 0 0 0", Busy, Done, HI, LO);
        end
    endtask

    task automatic test_mthi;
        @(negedge clk);
        issue(OP_MTHI, 32'hAAAA0000, 32'h0);
        checks++;
        if (HI !== 32'hAAAA0000 || Busy !== 1'b0 || Done !== 1'b0) begin
            fails++;
            $display("FAIL mthi: HI=%h Busy=%b Done=%b, want aaaa0000 0 0", HI, Busy, Done);
        end
        issue(OP_MTLO, 32'h5555AAAA, 32'h0);
        checks++;
        if (LO !== 32'h5555AAAA || HI !== 32'hAAAA0000 || Busy !== 1'b0) begin
            fails++;
            $display("FAIL mtlo: LO=%h HI=%h Busy=%b, want 5555aaaa aaaa0000 0", LO, HI, Busy);
        end
    endtask

    task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int cnt;
        @(negedge clk);
        issue(op, a, b);
        wait_idle(cnt);
        checks++;
        if (cnt !== 33) begin
            fails++;
            $display("FAIL %s_latency: busy cycles=%0d, want 33", name, cnt);
        end
        checks++;
        if (Done !== 1'b1 || HI !== ehi || LO !== elo) begin
            fails++;
            $display("FAIL %s_result: Done=%b HI=%h LO=%h, want 1 %h %h", name, Done, HI, LO, ehi, elo);
        end
        @(negedge clk);
        checks++;
        if (Done !== 1'b0) begin
            fails++;
            $display("FAIL %s_done_pulse: Done=%b in second cycle, want 0", name, Done);
        end
    endtask

    task automatic test_mult;
        run_op("mult",  OP_MULT,  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu", OP_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA);
    endtask

    task automatic test_div;
        run_op("div_neg",  OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_negb", OP_DIV,  32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu",     OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    endtask

    task automatic test_boundaries;
        run_op("divu_zero", OP_DIVU, 32'h00001234, 32'h0, 32'h00001234, 32'hFFFFFFFF);
        run_op("div_zero",  OP_DIV,  32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF);
        run_op("div_ovf",   OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    endtask

    task automatic test_start_while_busy;
        int cnt;
        @(negedge clk);
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        issue(OP_MTLO, 32'h0000DEAD, 32'h0);
        checks++;
        if (LO === 32'h0000DEAD || Busy !== 1'b1) begin
            fails++;
            $display("FAIL mtlo_busy_ignored: LO=%h Busy=%b, want LO!=0000dead Busy=1", LO, Busy);
        end
        wait_idle(cnt);
        checks++;
        if (Done !== 1'b1 || LO !== 32'd14 || HI !== 32'd2) begin
            fails++;
            $display("FAIL mtlo_busy_result: Done=%b HI=%h LO=%h, want 1 00000002 0000000e", Done, HI, LO);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int cnt;
        @(negedge clk);
        issue(OP_MULTU, 32'd3, 32'd5);
        wait_idle(cnt);
        checks++;
        if (Done !== 1'b1 || HI !== 32'd0 || LO !== 32'd15) begin
            fails++;
            $display("FAIL b2b_first: Done=%b HI=%h LO=%h, want 1 00000000 0000000f", Done, HI, LO);
        end
        issue(OP_DIVU, 32'd20, 32'd6);
        checks++;
        if (Busy !== 1'b1 || Done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_accept: Busy=%b Done=%b, want 1 0", Busy, Done);
        end
        wait_idle(cnt);
        checks++;
        if (cnt !== 33 || Done !== 1'b1 || HI !== 32'd2 || LO !== 32'd3) begin
            fails++;
            $display("FAIL b2b_second: cycles=%0d Done=%b HI=%h LO=%h, want 33 1 00000002 00000003", cnt, Done, HI, LO);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        int done_seen = 0;
        @(negedge clk);
        issue(OP_MTHI, 32'h00000055, 32'h0);
        issue(OP_MULT, 32'd7, 32'd9);
        repeat (9) @(negedge clk);
        checks++;
        if (Busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_busy: Busy=%b before reset, want 1", Busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            fails++;
            $display("FAIL reset_mid_op: Busy=%b Done=%b HI=%h LO=%h, want 0 0 0 0", Busy, Done, HI, LO);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done !== 1'b0 || Busy !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen !== 0 || HI !== 32'h0 || LO !== 32'h0) begin
            fails++;
            $display("FAIL reset_discard: activity cycles=%0d HI=%h LO=%h, want 0 0 0", done_seen, HI, LO);
        end
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; Op = 6'b0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_mthi();
        test_mult();
        test_div();
        test_boundaries();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
